// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic cells (adder, planned subtractor).
package serial_arith_pkg;

  // FSM encoding; 2'b11 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Majority of three bits: the carry of a full adder.
  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle between a requester and the serial adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_fa_cell.sv
// Single combinational full-adder cell used once per serial bit step.
module fa_cell
  import serial_arith_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = maj(a, b, ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one sum bit per clock, LSB first.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; sum/cout hold the last result
// ST_SHIFT | one full-adder step per clock, WIDTH steps in total
// ST_DONE  | result valid, done pulse; back to idle next clock
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_co;

  fa_cell u_fa (
    .a (ra_q[0]),
    .b (rb_q[0]),
    .ci(c_q),
    .s (fa_s),
    .co(fa_co)
  );

  // Next-state and datapath updates for the load / shift / done sequence.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          ra_d    = bus.a;
          rb_d    = bus.b;
          c_d     = bus.cin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ra_d  = {1'b0, ra_q[WIDTH-1:1]};
        rb_d  = {1'b0, rb_q[WIDTH-1:1]};
        sum_d = {fa_s, sum_q[WIDTH-1:1]};
        c_d   = fa_co;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cout_d  = fa_co;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything and aborts an operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign bus.done = (state_q == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
